// File: rtl/scp_pipe_pkg.sv
// Shared pipeline types for the operand fetch slice.
// Register index type, default widths, register count, one-hot helper.
package scp_pipe_pkg;

  localparam int NUM_REGS   = 16;
  localparam int DATA_W_DEF = 16;
  localparam int OP_W_DEF   = 8;

  typedef logic [3:0] reg_idx_t;

  function automatic logic [NUM_REGS-1:0] reg_bit(
    input reg_idx_t idx
  );
    return NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one bit per register marks an outstanding write.
// Ports: set_en/set_idx, clr_en/clr_idx, lookups rs0/rs1/rd -> busy_*.
module operand_fetch_scoreboard
  import scp_pipe_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t rs0,
  input  reg_idx_t rs1,
  input  reg_idx_t rd,
  output logic     busy_rs0,
  output logic     busy_rs1,
  output logic     busy_rd
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;

  assign clr_mask = clr_en ? reg_bit(clr_idx) : '0;
  assign set_mask = set_en ? reg_bit(set_idx) : '0;

  // Clear applied first so a same-cycle set on the same index wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  assign busy_rs0 = pending[rs0];
  assign busy_rs1 = pending[rs1];
  assign busy_rd  = pending[rd];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: hazard check, operand read/bypass, output register.
// Ports: in_* decoded instr, rf_* regfile read, wb_* write snoop, out_*.
// Macro OPERAND_FETCH_BYPASS_EN enables write-back to operand bypass.
module operand_fetch
  import scp_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_rs0,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rd,
  input  logic              in_rd_we,
  input  logic [OP_W-1:0]   in_op,
  output logic [3:0]        rf_rd0_sel,
  output logic [3:0]        rf_rd1_sel,
  input  logic [DATA_W-1:0] rf_rd0_data,
  input  logic [DATA_W-1:0] rf_rd1_data,
  input  logic              wb_valid,
  input  logic [3:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [3:0]        out_rd,
  output logic              out_rd_we,
  output logic [OP_W-1:0]   out_op
);

  logic              busy0;
  logic              busy1;
  logic              busy_rd;
  logic              haz0;
  logic              haz1;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  assign rf_rd0_sel = in_rs0;
  assign rf_rd1_sel = in_rs1;

`ifdef OPERAND_FETCH_BYPASS_EN
  logic byp0;
  logic byp1;

  assign byp0   = wb_valid && (wb_sel == in_rs0);
  assign byp1   = wb_valid && (wb_sel == in_rs1);
  assign opnd_a = byp0 ? wb_data : rf_rd0_data;
  assign opnd_b = byp1 ? wb_data : rf_rd1_data;
  assign haz0   = busy0 && !byp0;
  assign haz1   = busy1 && !byp1;
`else
  logic wb_data_unused;

  // Without bypass a source being written now waits for the rf update.
  assign wb_data_unused = ^wb_data;
  assign opnd_a = rf_rd0_data;
  assign opnd_b = rf_rd1_data;
  assign haz0   = busy0;
  assign haz1   = busy1;
`endif

  // A pending destination always stalls, even when retiring this cycle.
  assign hazard   = haz0 || haz1 || (in_rd_we && busy_rd);
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  operand_fetch_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept && in_rd_we),
    .set_idx  (in_rd),
    .clr_en   (wb_valid),
    .clr_idx  (wb_sel),
    .rs0      (in_rs0),
    .rs1      (in_rs1),
    .rd       (in_rd),
    .busy_rs0 (busy0),
    .busy_rs1 (busy1),
    .busy_rd  (busy_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_rd    <= '0;
      out_rd_we <= 1'b0;
      out_op    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_a     <= opnd_a;
      out_b     <= opnd_b;
      out_rd    <= in_rd;
      out_rd_we <= in_rd_we;
      out_op    <= in_op;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus a
// randomized run against a register-level behavioural model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rs0;
  logic [3:0]  in_rs1;
  logic [3:0]  in_rd;
  logic        in_rd_we;
  logic [7:0]  in_op;
  logic [3:0]  rf_rd0_sel;
  logic [3:0]  rf_rd1_sel;
  logic [15:0] rf_rd0_data;
  logic [15:0] rf_rd1_data;
  logic        wb_valid;
  logic [3:0]  wb_sel;
  logic [15:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [3:0]  out_rd;
  logic        out_rd_we;
  logic [7:0]  out_op;

  logic [15:0] rf [16];
  int n_cmp = 0;
  int n_bad = 0;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  assign rf_rd0_data = rf[rf_rd0_sel];
  assign rf_rd1_data = rf[rf_rd1_sel];

  operand_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs0      (in_rs0),
    .in_rs1      (in_rs1),
    .in_rd       (in_rd),
    .in_rd_we    (in_rd_we),
    .in_op       (in_op),
    .rf_rd0_sel  (rf_rd0_sel),
    .rf_rd1_sel  (rf_rd1_sel),
    .rf_rd0_data (rf_rd0_data),
    .rf_rd1_data (rf_rd1_data),
    .wb_valid    (wb_valid),
    .wb_sel      (wb_sel),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_rd      (out_rd),
    .out_rd_we   (out_rd_we),
    .out_op      (out_op)
  );

  task automatic idle_inputs();
    in_valid = 0; in_rs0 = 0; in_rs1 = 0;
    in_rd = 0; in_rd_we = 0; in_op = 0;
    wb_valid = 0; wb_sel = 0; wb_data = 0;
  endtask

  // Regfile write lands at the edge, like the real write port.
  task automatic tick();
    @(posedge clk);
    if (wb_valid) rf[wb_sel] = wb_data;
    #1;
  endtask

  task automatic drive(
    input logic [3:0] rs0, input logic [3:0] rs1,
    input logic [3:0] rd, input logic we, input logic [7:0] op
  );
    in_valid = 1; in_rs0 = rs0; in_rs1 = rs1;
    in_rd = rd; in_rd_we = we; in_op = op;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    out_ready = 1;
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    #1;
    n_cmp++;
    if (out_valid !== 0 || out_a !== 0 || out_b !== 0 ||
        out_rd !== 0 || out_rd_we !== 0 || out_op !== 0) begin
      n_bad++;
      $display("FAIL reset_outs got v=%b a=%h b=%h rd=%h we=%b op=%h want 0",
               out_valid, out_a, out_b, out_rd, out_rd_we, out_op);
    end
    n_cmp++;
    if (dut.u_sb.pending !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_pending got %h want 0000", dut.u_sb.pending);
    end
    @(negedge clk);
    rst = 0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    rf[1] = 16'h1111; rf[2] = 16'h2222;
    drive(4'd1, 4'd2, 4'd3, 1'b1, 8'h5A);
    tick();
    n_cmp++;
    if (out_valid !== 1 || out_a !== 16'h1111 || out_b !== 16'h2222 ||
        out_rd !== 3 || out_rd_we !== 1 || out_op !== 8'h5A) begin
      n_bad++;
      $display("FAIL basic_out got v=%b a=%h b=%h rd=%h op=%h want 1 1111 2222 3 5a",
               out_valid, out_a, out_b, out_rd, out_op);
    end
    n_cmp++;
    if (dut.u_sb.pending[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_pend3 got %b want 1", dut.u_sb.pending[3]);
    end
  endtask

  task automatic test_raw();
    // Continues from test_basic: r3 pending, output draining.
    @(negedge clk);
    drive(4'd3, 4'd0, 4'd4, 1'b0, 8'h33);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL raw_stall%0d got %b want 0", i, in_ready);
      end
      tick();
      @(negedge clk);
    end
    wb_valid = 1; wb_sel = 4'd3; wb_data = 16'hBEEF;
    #1;
    n_cmp++;
    if (in_ready !== BYP) begin
      n_bad++;
      $display("FAIL raw_wb_ready got %b want %b", in_ready, BYP);
    end
    tick();
    if (!BYP) begin
      @(negedge clk);
      wb_valid = 0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL raw_late_ready got %b want 1", in_ready);
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1 || out_a !== 16'hBEEF || out_op !== 8'h33) begin
      n_bad++;
      $display("FAIL raw_out got v=%b a=%h op=%h want 1 beef 33",
               out_valid, out_a, out_op);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    do_reset();
    drive(4'd6, 4'd7, 4'd8, 1'b0, 8'h11);
    out_ready = 0;
    held = rf[6];
    tick();
    @(negedge clk);
    drive(4'd9, 4'd10, 4'd11, 1'b0, 8'h22);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (in_ready !== 0 || out_valid !== 1 || out_a !== held ||
          out_op !== 8'h11) begin
        n_bad++;
        $display("FAIL bp_hold%0d got rdy=%b v=%b a=%h op=%h want 0 1 %h 11",
                 i, in_ready, out_valid, out_a, out_op, held);
      end
      tick();
      @(negedge clk);
    end
    out_ready = 1;
    held = rf[9];
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release got %b want 1", in_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1 || out_a !== held || out_op !== 8'h22) begin
      n_bad++;
      $display("FAIL bp_replace got v=%b a=%h op=%h want 1 %h 22",
               out_valid, out_a, out_op, held);
    end
    @(negedge clk);
    idle_inputs();
    tick();
    n_cmp++;
    if (out_valid !== 0 || out_a !== held) begin
      n_bad++;
      $display("FAIL bp_drain got v=%b a=%h want 0 %h",
               out_valid, out_a, held);
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    drive(4'd0, 4'd1, 4'd5, 1'b1, 8'h55);
    wb_valid = 1; wb_sel = 4'd5; wb_data = 16'h0505;
    tick();
    n_cmp++;
    if (dut.u_sb.pending[5] !== 1'b1) begin
      n_bad++;
      $display("FAIL set_wins got %b want 1", dut.u_sb.pending[5]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(4'(8 + i), 4'(15 - i), 4'(i), 1'b0, 8'(8'hA0 + i));
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_ready%0d got %b want 1", i, in_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1 || out_op !== 8'(8'hA0 + i) ||
          out_a !== rf[8 + i]) begin
        n_bad++;
        $display("FAIL b2b_out%0d got v=%b op=%h a=%h want 1 %h %h",
                 i, out_valid, out_op, out_a, 8'(8'hA0 + i), rf[8 + i]);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 0;
    drive(4'd0, 4'd1, 4'd3, 1'b1, 8'h01);
    tick();
    @(negedge clk);
    out_ready = 1;
    drive(4'd0, 4'd1, 4'd5, 1'b1, 8'h02);
    tick();
    @(negedge clk);
    idle_inputs();
    out_ready = 0;
    #1;
    n_cmp++;
    if (dut.u_sb.pending !== 16'h0028 || out_valid !== 1) begin
      n_bad++;
      $display("FAIL mid_setup got pend=%h v=%b want 0028 1",
               dut.u_sb.pending, out_valid);
    end
    rst = 1;
    #1;
    n_cmp++;
    if (out_valid !== 0 || dut.u_sb.pending !== 16'h0 || out_op !== 0) begin
      n_bad++;
      $display("FAIL mid_reset got v=%b pend=%h op=%h want 0 0000 00",
               out_valid, dut.u_sb.pending, out_op);
    end
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    drive(4'd3, 4'd5, 4'd5, 1'b1, 8'h03);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_first_accept got %b want 1", in_ready);
    end
    tick();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    bit          m_pend [16];
    bit          m_ov;
    logic [15:0] m_a, m_b;
    logic [3:0]  m_rd;
    logic        m_we;
    logic [7:0]  m_op;
    logic [15:0] va, vb;
    bit          blk, rdy, acc;
    int          cand [$];
    do_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_ov = 0;
    m_a = 0; m_b = 0; m_rd = 0; m_we = 0; m_op = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_rs0    = 4'($urandom);
      in_rs1    = 4'($urandom);
      in_rd     = 4'($urandom);
      in_rd_we  = $urandom_range(0, 1) == 1;
      in_op     = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cand.delete();
      for (int r = 0; r < 16; r++) if (m_pend[r]) cand.push_back(r);
      wb_valid = 0; wb_sel = 0; wb_data = 16'($urandom);
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        wb_valid = 1;
        wb_sel = 4'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      va = (BYP && wb_valid && wb_sel == in_rs0) ? wb_data : rf[in_rs0];
      vb = (BYP && wb_valid && wb_sel == in_rs1) ? wb_data : rf[in_rs1];
      blk = (m_pend[in_rs0] && !(BYP && wb_valid && wb_sel == in_rs0)) ||
            (m_pend[in_rs1] && !(BYP && wb_valid && wb_sel == in_rs1)) ||
            (in_rd_we && m_pend[in_rd]);
      rdy = !blk && (!m_ov || out_ready);
      acc = in_valid && rdy;
      #1;
      n_cmp++;
      if (in_ready !== rdy || rf_rd0_sel !== in_rs0 ||
          rf_rd1_sel !== in_rs1) begin
        n_bad++;
        $display("FAIL rnd_ready c=%0d got %b sel=%h/%h want %b %h/%h",
                 c, in_ready, rf_rd0_sel, rf_rd1_sel, rdy, in_rs0, in_rs1);
      end
      if (wb_valid) m_pend[wb_sel] = 0;
      if (acc) begin
        if (in_rd_we) m_pend[in_rd] = 1;
        m_ov = 1; m_a = va; m_b = vb;
        m_rd = in_rd; m_we = in_rd_we; m_op = in_op;
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
      tick();
      n_cmp++;
      if (out_valid !== m_ov || out_a !== m_a || out_b !== m_b ||
          out_rd !== m_rd || out_rd_we !== m_we || out_op !== m_op) begin
        n_bad++;
        $display("FAIL rnd_out c=%0d got %b %h %h %h %b %h want %b %h %h %h %b %h",
                 c, out_valid, out_a, out_b, out_rd, out_rd_we, out_op,
                 m_ov, m_a, m_b, m_rd, m_we, m_op);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    out_ready = 1;
    idle_inputs();
    for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
    test_reset();
    test_basic();
    test_raw();
    test_backpressure();
    test_set_wins();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
